// File: rtl/ifetch_buf_if.sv
// ifetch_buf_if: bundles the instruction-memory bus (req/gnt/rvalid) and the
// decode-side valid/ready handshake of the prefetch buffer.
//   master : the prefetch buffer (drives mem_req_o/mem_addr_o and ins_*_o)
//   slave  : memory + decode side (drives mem_gnt_i/mem_rvalid_i/mem_rdata_i, ins_ready_i)
interface ifetch_buf_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              mem_req_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic              mem_gnt_i;
    logic              mem_rvalid_i;
    logic [DATA_W-1:0] mem_rdata_i;
    logic              ins_valid_o;
    logic              ins_ready_i;
    logic [DATA_W-1:0] ins_o;
    logic [ADDR_W-1:0] ins_addr_o;

    modport master (
        output mem_req_o, mem_addr_o, ins_valid_o, ins_o, ins_addr_o,
        input  mem_gnt_i, mem_rvalid_i, mem_rdata_i, ins_ready_i
    );

    modport slave (
        input  mem_req_o, mem_addr_o, ins_valid_o, ins_o, ins_addr_o,
        output mem_gnt_i, mem_rvalid_i, mem_rdata_i, ins_ready_i
    );
endinterface

// File: rtl/ifetch_buf.sv
// ifetch_buf: instruction prefetch buffer.
// Owns the fetch PC, issues sequential word fetches on a req/gnt/rvalid bus,
// queues returned {addr,inst} pairs in an in-order FIFO and presents the head
// to decode with valid/ready. A jump redirects fetch, empties the FIFO and
// drops responses still in flight from the old stream.
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   jump_flag, jump_addr redirect request and word-aligned target
//   bus (master)         mem_req_o/mem_addr_o/mem_gnt_i/mem_rvalid_i/mem_rdata_i,
//                        ins_valid_o/ins_ready_i/ins_o/ins_addr_o
module ifetch_buf #(
    parameter int                DEPTH    = 4,
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [DATA_W-1:0] NOP_INST = 32'h0000_0013
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              jump_flag,
    input  logic [ADDR_W-1:0] jump_addr,
    ifetch_buf_if.master      bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [ADDR_W-1:0] fetch_pc, redir_addr;
    logic              lock, redir_pend;
    logic [CW-1:0]     count, outstanding, discard;
    logic [PW-1:0]     wr_ptr, rd_ptr, aq_wr, aq_rd;
    logic [CW:0]       total;

    // Address queue: addresses of issued requests, popped as responses return.
    logic [ADDR_W-1:0] aq_mem [DEPTH];
    // Instruction FIFO storage.
    logic [ADDR_W-1:0] q_addr [DEPTH];
    logic [DATA_W-1:0] q_data [DEPTH];

    logic gnt, rvalid, stalled, push, pop;

    assign gnt     = bus.mem_gnt_i;
    assign rvalid  = bus.mem_rvalid_i;
    // A visible, not-yet-accepted request must stay put on the bus, so a jump
    // in such a cycle cannot move fetch_pc and is parked in redir_addr instead.
    assign stalled = bus.mem_req_o & ~gnt;
    assign push    = rvalid & (discard == '0) & ~jump_flag;
    assign pop     = bus.ins_valid_o & bus.ins_ready_i & ~jump_flag;

    // Credit counts discarded requests too, so the FIFO can never overflow.
    assign total          = {1'b0, count} + {1'b0, outstanding};
    assign bus.mem_req_o  = lock | (~rst & (total < (CW+1)'(DEPTH)));
    assign bus.mem_addr_o = fetch_pc;
    assign bus.ins_valid_o = (count != '0);
    assign bus.ins_o       = bus.ins_valid_o ? q_data[rd_ptr] : NOP_INST;
    assign bus.ins_addr_o  = bus.ins_valid_o ? q_addr[rd_ptr] : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            redir_addr  <= '0;
            redir_pend  <= 1'b0;
            lock        <= 1'b0;
            count       <= '0;
            outstanding <= '0;
            discard     <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            aq_wr       <= '0;
            aq_rd       <= '0;
        end else begin
            lock        <= stalled;
            outstanding <= outstanding + CW'(gnt) - CW'(rvalid);
            if (gnt)    aq_wr <= aq_wr + PW'(1);
            if (rvalid) aq_rd <= aq_rd + PW'(1);

            if (jump_flag && !stalled) begin
                fetch_pc   <= jump_addr;
                redir_pend <= 1'b0;
            end else if (gnt) begin
                fetch_pc   <= redir_pend ? redir_addr : fetch_pc + ADDR_W'(4);
                redir_pend <= 1'b0;
            end
            if (jump_flag && stalled) begin
                redir_pend <= 1'b1;
                redir_addr <= jump_addr;
            end

            // Everything granted up to and including a jump cycle is old-stream.
            // A held request granted later is counted in when its gnt arrives.
            if (jump_flag)
                discard <= outstanding + CW'(gnt) - CW'(rvalid);
            else
                discard <= discard - CW'(rvalid && discard != '0) + CW'(gnt && redir_pend);

            if (jump_flag) begin
                count  <= '0;
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PW'(1);
                if (pop)  rd_ptr <= rd_ptr + PW'(1);
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    // Storage arrays need no reset; validity is tracked by the counters.
    always_ff @(posedge clk) begin
        if (gnt && !rst)
            aq_mem[aq_wr] <= fetch_pc;
        if (push && !rst) begin
            q_addr[wr_ptr] <= aq_mem[aq_rd];
            q_data[wr_ptr] <= bus.mem_rdata_i;
        end
    end
endmodule

// File: tb/tb_ifetch_buf.sv
// tb_ifetch_buf: randomized bench for ifetch_buf. A memory model answers
// granted requests in order after a random latency; the reference model tracks
// the expected instruction stream per redirect epoch, FIFO occupancy and
// credit, and checks every popped instruction against it.
module tb_ifetch_buf;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        jump_flag = 1'b0;
    logic [31:0] jump_addr = '0;

    ifetch_buf_if bus ();

    ifetch_buf #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .jump_flag (jump_flag),
        .jump_addr (jump_addr),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
        int          ep;
    } resp_t;

    int n_chk = 0, n_err = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {~a[15:0], a[15:0]};
    endfunction

    // reference model state
    resp_t       resp_q[$];
    int          cyc = 0, m_out = 0, m_fifo = 0, epoch = 0, last_due = 0, n_gnt = 0;
    logic [31:0] exp_addr, issue_pc, held_addr;
    bit          stale = 0, held_q = 0;

    // stimulus knobs
    int          p_gnt = 100, p_ready = 100, p_jump = 0, lat_min = 1, lat_max = 1;
    bit          force_jump = 0, jump_on_collide = 0, jump_at_out2 = 0;
    logic [31:0] force_addr = '0;

    task automatic apply_reset();
        rst = 1'b1;
        bus.mem_gnt_i = 1'b0; bus.mem_rvalid_i = 1'b0; bus.mem_rdata_i = '0;
        bus.ins_ready_i = 1'b0; jump_flag = 1'b0; jump_addr = '0;
        #1;
        chk("rst_req",   32'(bus.mem_req_o), 0);
        chk("rst_valid", 32'(bus.ins_valid_o), 0);
        chk("rst_ins",   bus.ins_o, NOP);
        chk("rst_addr",  bus.ins_addr_o, 0);
        resp_q.delete();
        m_out = 0; m_fifo = 0; last_due = 0;
        exp_addr = RESET_PC; issue_pc = RESET_PC; stale = 0; held_q = 0;
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    // One bus cycle: sample outputs, drive inputs, advance the model.
    task automatic step();
        logic        req, g, rv, rdy, jf;
        logic [31:0] ja;
        resp_t       e;
        int          due;
        req = bus.mem_req_o;
        if (held_q) begin
            chk("req_held",  32'(req), 1);
            chk("addr_held", bus.mem_addr_o, held_addr);
        end else begin
            chk("credit", 32'(req), 32'(m_out + m_fifo < DEPTH));
        end
        chk("ins_valid", 32'(bus.ins_valid_o), 32'(m_fifo != 0));
        if (!bus.ins_valid_o) begin
            chk("empty_ins",  bus.ins_o, NOP);
            chk("empty_addr", bus.ins_addr_o, 0);
        end

        g   = req && (int'($urandom_range(0, 99)) < p_gnt);
        rv  = (resp_q.size() != 0) && (resp_q[0].due <= cyc);
        rdy = int'($urandom_range(0, 99)) < p_ready;
        jf  = force_jump || (int'($urandom_range(0, 999)) < p_jump)
              || (jump_on_collide && rv && bus.ins_valid_o && rdy)
              || (jump_at_out2 && m_out == 2);
        ja  = (force_jump || jump_at_out2) ? force_addr : (32'($urandom_range(0, 1023)) << 2);

        bus.mem_gnt_i    = g;
        bus.mem_rvalid_i = rv;
        bus.mem_rdata_i  = rv ? mem_word(resp_q[0].addr) : '0;
        bus.ins_ready_i  = rdy;
        jump_flag        = jf;
        jump_addr        = ja;

        if (bus.ins_valid_o && rdy && !jf) begin
            chk("pop_addr", bus.ins_addr_o, exp_addr);
            chk("pop_data", bus.ins_o, mem_word(exp_addr));
            exp_addr += 4;
            if (m_fifo > 0) m_fifo--;
        end
        if (g) begin
            n_gnt++;
            e.addr = bus.mem_addr_o;
            e.ep   = stale ? -1 : epoch;
            if (stale) stale = 0;
            else begin
                chk("req_addr", bus.mem_addr_o, issue_pc);
                issue_pc += 4;
            end
            due = cyc + int'($urandom_range(lat_min, lat_max));
            if (due < last_due) due = last_due;
            last_due = due;
            e.due = due;
            resp_q.push_back(e);
            m_out++;
        end
        if (rv) begin
            e = resp_q.pop_front();
            m_out--;
            if (!jf && e.ep == epoch) m_fifo++;
        end
        if (jf) begin
            m_fifo = 0; epoch++;
            exp_addr = ja; issue_pc = ja;
            if (req && !g) stale = 1;
            force_jump = 0; jump_at_out2 = 0; jump_on_collide = 0;
        end
        held_q    = req && !g;
        held_addr = bus.mem_addr_o;
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    initial begin
        #1;
        apply_reset();

        // straight-line stream, gnt every cycle, 1-cycle response
        repeat (12) step();

        // decode stalled: credit stops issue at DEPTH
        apply_reset();
        p_ready = 0; n_gnt = 0;
        repeat (10) step();
        chk("stall_gnts", 32'(n_gnt), DEPTH);
        chk("stall_req",  32'(bus.mem_req_o), 0);
        chk("stall_head", bus.ins_addr_o, 0);
        chk("stall_ins",  bus.ins_o, mem_word(0));
        p_ready = 100;
        repeat (20) step();

        // 3-cycle memory, jump to 0x100 with 2 outstanding
        lat_min = 3; lat_max = 3; force_addr = 32'h100; jump_at_out2 = 1;
        repeat (20) step();
        chk("jump_out2_taken", 32'(jump_at_out2), 0);

        // held request at 0x8 while gnt low, jump to 0x200 mid-hold
        apply_reset();
        lat_min = 1; lat_max = 1;
        step(); step();
        chk("held_pre", bus.mem_addr_o, 32'h8);
        p_gnt = 0;
        step();
        force_jump = 1; force_addr = 32'h200;
        step(); step(); step();
        chk("held_post", bus.mem_addr_o, 32'h8);
        p_gnt = 100;
        repeat (12) step();

        // jump colliding with rvalid and a pop in the same cycle
        lat_max = 2; jump_on_collide = 1;
        repeat (30) step();
        chk("collide_taken", 32'(jump_on_collide), 0);

        // random traffic
        p_gnt = 70; p_ready = 70; lat_min = 1; lat_max = 5; p_jump = 15;
        repeat (3000) step();

        // reset with 3 entries queued
        p_jump = 0; p_gnt = 100; p_ready = 0; lat_min = 1; lat_max = 1;
        for (int i = 0; i < 60 && m_fifo != 3; i++) step();
        chk("fill3_valid", 32'(bus.ins_valid_o), 1);
        @(negedge clk);
        apply_reset();
        chk("post_rst_addr", bus.mem_addr_o, RESET_PC);
        chk("post_rst_req",  32'(bus.mem_req_o), 1);
        p_ready = 100;
        repeat (10) step();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
